// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index type and hazard-controller state encoding.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [2:0] {
    RUN      = 3'd0,
    MEM_WAIT = 3'd1,
    LOAD_USE = 3'd2,
    REDIRECT = 3'd3,
    HALTED   = 3'd4
  } hctrl_state_t;

  localparam logic [15:0] STALL_MAX = 16'hFFFF;

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use detector: a load in ID/EX whose destination feeds the IF/ID instruction.
module hazard_detect
  import cpu_types_pkg::*;
(
  input  logic     idex_dREN,
  input  regbits_t idex_rt,
  input  regbits_t ifid_rs,
  input  regbits_t ifid_rt,
  input  logic     ifid_uses_rt,
  output logic     load_use
);

  // $0 is hardwired, so a load targeting it never creates a dependency.
  assign load_use = idex_dREN && (idex_rt != '0) &&
                    ((idex_rt == ifid_rs) || (ifid_uses_rt && (idex_rt == ifid_rt)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-register enables/flushes, stall counter, sticky halt.
module pipeline_hazard_ctrl
  import cpu_types_pkg::*;
(
  input  logic         CLK,
  input  logic         nRST,
  input  logic         ihit,
  input  logic         dhit,
  input  logic         dmem_req,
  input  logic         idex_dREN,
  input  regbits_t     idex_rt,
  input  regbits_t     ifid_rs,
  input  regbits_t     ifid_rt,
  input  logic         ifid_uses_rt,
  input  logic         redirect,
  input  logic         wb_halt,
  output logic         pc_en,
  output logic         ifid_en,
  output logic         ifid_flush,
  output logic         idex_en,
  output logic         idex_flush,
  output logic         exmem_en,
  output logic         exmem_flush,
  output logic         memwb_en,
  output logic         halt_out,
  output hctrl_state_t state,
  output logic [15:0]  stall_count
);

  hctrl_state_t next_state;
  logic load_use;
  logic evaluate;
  logic pc_en_c, ifid_en_c, idex_en_c, exmem_en_c, memwb_en_c;
  logic ifid_flush_c, idex_flush_c, exmem_flush_c;

  hazard_detect u_hazard_detect (
    .idex_dREN    (idex_dREN),
    .idex_rt      (idex_rt),
    .ifid_rs      (ifid_rs),
    .ifid_rt      (ifid_rt),
    .ifid_uses_rt (ifid_uses_rt),
    .load_use     (load_use)
  );

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= RUN;
    else       state <= next_state;
  end

  // The dhit cycle of MEM_WAIT resolves exactly like RUN so pending redirects are kept.
  assign evaluate = (state == RUN) || (state == LOAD_USE) || (state == REDIRECT) ||
                    ((state == MEM_WAIT) && dhit);

  always_comb begin
    next_state    = state;
    pc_en_c       = 1'b0;
    ifid_en_c     = 1'b0;
    idex_en_c     = 1'b0;
    exmem_en_c    = 1'b0;
    memwb_en_c    = 1'b0;
    ifid_flush_c  = 1'b0;
    idex_flush_c  = 1'b0;
    exmem_flush_c = 1'b0;
    if (evaluate) begin
      if (wb_halt) begin
        next_state = HALTED;
      end else if (dmem_req && !dhit) begin
        next_state = MEM_WAIT;
      end else if (redirect) begin
        next_state    = REDIRECT;
        pc_en_c       = 1'b1;
        ifid_en_c     = 1'b1;
        idex_en_c     = 1'b1;
        exmem_en_c    = 1'b1;
        memwb_en_c    = 1'b1;
        ifid_flush_c  = 1'b1;
        idex_flush_c  = 1'b1;
        exmem_flush_c = 1'b1;
      end else if (load_use && (state != REDIRECT)) begin
        next_state   = LOAD_USE;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        idex_flush_c = 1'b1;
      end else if (!ihit) begin
        next_state   = RUN;
        ifid_en_c    = 1'b1;
        idex_en_c    = 1'b1;
        exmem_en_c   = 1'b1;
        memwb_en_c   = 1'b1;
        ifid_flush_c = 1'b1;
      end else begin
        next_state = RUN;
        pc_en_c    = 1'b1;
        ifid_en_c  = 1'b1;
        idex_en_c  = 1'b1;
        exmem_en_c = 1'b1;
        memwb_en_c = 1'b1;
      end
    end
  end

  // Reset must silence the Mealy outputs immediately, independent of the clock.
  assign pc_en       = nRST & pc_en_c;
  assign ifid_en     = nRST & ifid_en_c;
  assign idex_en     = nRST & idex_en_c;
  assign exmem_en    = nRST & exmem_en_c;
  assign memwb_en    = nRST & memwb_en_c;
  assign ifid_flush  = nRST & ifid_flush_c;
  assign idex_flush  = nRST & idex_flush_c;
  assign exmem_flush = nRST & exmem_flush_c;
  assign halt_out    = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_count <= '0;
    end else if (!pc_en && (state != HALTED) && (stall_count != STALL_MAX)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with hand-computed expectations.
module tb_pipeline_hazard_ctrl;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST;
  logic ihit, dhit, dmem_req, idex_dREN, ifid_uses_rt, redirect, wb_halt;
  regbits_t idex_rt, ifid_rs, ifid_rt;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, exmem_flush, memwb_en;
  logic halt_out;
  hctrl_state_t state;
  logic [15:0] stall_count;

  int total = 0;
  int bad = 0;

  pipeline_hazard_ctrl dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .idex_dREN(idex_dREN), .idex_rt(idex_rt), .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .ifid_uses_rt(ifid_uses_rt), .redirect(redirect), .wb_halt(wb_halt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .exmem_en(exmem_en), .exmem_flush(exmem_flush),
    .memwb_en(memwb_en), .halt_out(halt_out), .state(state), .stall_count(stall_count)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // en = {pc, ifid, idex, exmem, memwb}; fl = {ifid, idex, exmem}
  task automatic chk_ctl(input string tag, input logic [4:0] en, input logic [2:0] fl);
    #2;
    chk({tag, ".en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
    chk({tag, ".fl"}, {29'd0, ifid_flush, idex_flush, exmem_flush}, {29'd0, fl});
  endtask

  task automatic chk_st(input string tag, input hctrl_state_t s, input logic h, input logic [15:0] c);
    chk({tag, ".state"}, {29'd0, state}, {29'd0, s});
    chk({tag, ".halt"}, {31'd0, halt_out}, {31'd0, h});
    chk({tag, ".cnt"}, {16'd0, stall_count}, {16'd0, c});
  endtask

  task automatic idle_inputs();
    ihit = 1'b1; dhit = 1'b0; dmem_req = 1'b0; idex_dREN = 1'b0; idex_rt = '0;
    ifid_rs = '0; ifid_rt = '0; ifid_uses_rt = 1'b0; redirect = 1'b0; wb_halt = 1'b0;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs();
    #2;
    chk_ctl("reset", 5'b00000, 3'b000);
    chk_st("reset", RUN, 1'b0, 16'd0);
    #10 nRST = 1'b1;
    tick();

    // normal advance
    chk_ctl("advance", 5'b11111, 3'b000);
    tick();
    chk_st("advance", RUN, 1'b0, 16'd0);

    // load-use on rs
    idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    chk_ctl("lu_rs", 5'b00111, 3'b010);
    tick();
    chk_st("lu_rs", LOAD_USE, 1'b0, 16'd1);
    idex_dREN = 1'b0;
    chk_ctl("lu_after", 5'b11111, 3'b000);
    tick();
    chk_st("lu_after", RUN, 1'b0, 16'd1);

    // rt match only counts when the instruction reads rt
    idex_dREN = 1'b1; idex_rt = 5'd7; ifid_rs = 5'd3; ifid_rt = 5'd7;
    chk_ctl("rt_unused", 5'b11111, 3'b000);
    ifid_uses_rt = 1'b1;
    chk_ctl("lu_rt", 5'b00111, 3'b010);
    tick();
    idle_inputs();
    tick();
    chk_st("lu_rt", RUN, 1'b0, 16'd2);

    // load to $0 never stalls
    idex_dREN = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0;
    chk_ctl("zero_reg", 5'b11111, 3'b000);
    tick();
    chk_st("zero_reg", RUN, 1'b0, 16'd2);
    idle_inputs();

    // instruction miss
    ihit = 1'b0;
    chk_ctl("imiss", 5'b01111, 3'b100);
    tick();
    chk_st("imiss", RUN, 1'b0, 16'd3);
    ihit = 1'b1;

    // data wait with a pending redirect: three frozen cycles, then redirect on dhit
    dmem_req = 1'b1; redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk_ctl("mwait", 5'b00000, 3'b000);
      tick();
      chk_st("mwait", MEM_WAIT, 1'b0, 16'(4 + i));
    end
    dhit = 1'b1;
    chk_ctl("mwait_hit", 5'b11111, 3'b111);
    tick();
    chk_st("mwait_hit", REDIRECT, 1'b0, 16'd6);

    // load-use ignored for the bubble cycle after a redirect
    idle_inputs();
    idex_dREN = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5;
    chk_ctl("redir_lu_ign", 5'b11111, 3'b000);
    tick();
    chk_st("redir_lu_ign", RUN, 1'b0, 16'd6);

    // redirect beats load-use; next cycle no stall
    redirect = 1'b1;
    chk_ctl("redir_lu", 5'b11111, 3'b111);
    tick();
    chk_st("redir_lu", REDIRECT, 1'b0, 16'd6);
    redirect = 1'b0;
    chk_ctl("redir_next", 5'b11111, 3'b000);
    tick();
    chk_st("redir_next", RUN, 1'b0, 16'd6);
    idle_inputs();

    // halt outranks redirect; the halt cycle itself has pc_en=0 and counts
    wb_halt = 1'b1; redirect = 1'b1;
    chk_ctl("halt", 5'b00000, 3'b000);
    tick();
    chk_st("halt", HALTED, 1'b1, 16'd7);
    wb_halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ihit = 1'($urandom_range(0, 1));
      dhit = 1'($urandom_range(0, 1));
      redirect = 1'($urandom_range(0, 1));
      chk_ctl("halted", 5'b00000, 3'b000);
      tick();
      chk_st("halted", HALTED, 1'b1, 16'd7);
    end

    // asynchronous reset out of HALTED
    #2 nRST = 1'b0;
    #1;
    chk_st("rst_halted", RUN, 1'b0, 16'd0);
    idle_inputs();
    #3 nRST = 1'b1;
    tick();
    chk_ctl("post_rst", 5'b11111, 3'b000);

    // saturation
    ihit = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    chk_st("sat_m1", RUN, 1'b0, 16'hFFFE);
    tick();
    chk_st("sat", RUN, 1'b0, 16'hFFFF);
    for (int i = 0; i < 4465; i++) tick();
    chk_st("sat_hold", RUN, 1'b0, 16'hFFFF);
    chk_ctl("sat_ctl", 5'b01111, 3'b100);

    // mid-cycle asynchronous reset
    nRST = 1'b0;
    chk_ctl("rst_mid", 5'b00000, 3'b000);
    chk_st("rst_mid", RUN, 1'b0, 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
